// File: rtl/led_count_sched.sv
// Two-requester round-robin front end for a shared LED count sequencer.
// Each grant runs led through 0..MAX_COUNT at the tick rate, then holds done[owner] for one tick.
module led_count_sched #(
  parameter int TICK_DIV  = 1500000,
  parameter int MAX_COUNT = 15,
  parameter int LED_W     = 4
) (
  input  logic             clk,
  input  logic             rst_btn,
  input  logic [1:0]       req,
  output logic [LED_W-1:0] led,
  output logic             busy,
  output logic             owner,
  output logic [1:0]       done
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [LED_W-1:0] LED_MAX   = LED_W'(MAX_COUNT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [LED_W-1:0] led_q;
  logic             busy_q;
  logic             owner_q;
  logic             last_owner_q;
  logic [1:0]       done_q;
  logic [1:0]       pending_q;
  logic [1:0]       pending_d;

  logic             tick_s;
  logic             grant_s;
  logic             grantee_s;
  logic [1:0]       clr_s;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  assign tick_s = (cnt_q == TICK_LAST);

  // Arbitration: ties go to the requester that did not win last time.
  always_comb begin
    grant_s   = 1'b0;
    grantee_s = 1'b0;
    clr_s     = 2'b00;
    if ((state_q == IDLE) && (pending_q != 2'b00)) begin
      grant_s = 1'b1;
      if (pending_q == 2'b11) begin
        grantee_s = ~last_owner_q;
      end else begin
        grantee_s = pending_q[1];
      end
      clr_s = onehot2(grantee_s);
    end else begin
      grant_s = 1'b0;
    end
    pending_d = (pending_q & ~clr_s) | req;
  end

  // Pending latch: one outstanding request per requester, a same-cycle req re-arms it.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      pending_q <= 2'b00;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      led_q        <= '0;
      busy_q       <= 1'b0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      done_q       <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          led_q  <= '0;
          done_q <= 2'b00;
          if (grant_s) begin
            state_q      <= COUNT;
            busy_q       <= 1'b1;
            owner_q      <= grantee_s;
            last_owner_q <= grantee_s;
          end else begin
            busy_q <= 1'b0;
          end
        end
        COUNT: begin
          if (tick_s) begin
            cnt_q <= '0;
            if (led_q == LED_MAX) begin
              state_q <= DONE;
              done_q  <= onehot2(owner_q);
            end else begin
              led_q <= led_q + LED_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (tick_s) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 2'b00;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          led_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 2'b00;
        end
      endcase
    end
  end

  assign led   = led_q;
  assign busy  = busy_q;
  assign owner = owner_q;
  assign done  = done_q;

endmodule

// File: doc/led_count_sched.md
Name: led_count_sched

Overview:
- Round-robin scheduler that shares one LED count sequencer between two requesters (go sources).
- Each request earns one full 0..MAX_COUNT count on the LED bank at the divided tick rate, followed by a one-tick done indication to that requester.
- Sits between the debounced, edge-detected go pulses and the board LEDs. It replaces a single-owner counting FSM wherever two buttons or agents contend for the display.

Parameters:
- TICK_DIV, 1500000, clk cycles per count tick (>=2); tick counter width = $clog2(TICK_DIV).
- MAX_COUNT, 15, terminal LED value; must fit in LED_W bits.
- LED_W, 4, LED bus width.

Ports:
- clk  in  1  system clock (12 MHz on board)
- rst_btn  in  1  reset, asynchronous, active-low
- req  in  2  single-cycle go pulses, one bit per requester; already debounced and edge-detected, synchronous to clk
- led  out  LED_W  current count value
- busy  out  1  high whenever state != IDLE
- owner  out  1  index of the requester currently granted; valid while busy
- done  out  2  done[owner] high for the whole DONE state; all other bits 0

Behaviour:
- Reset (rst_btn=0, async) values:
  - state=IDLE, led=0, busy=0, owner=0, done=0
  - pending=2'b00, tick counter=0
  - last_owner=1, so requester 0 wins the first tie
- Pending latch:
  - req[i]=1 sets pending[i] on the next edge, in any state.
  - A repeat request while pending[i] is already 1 is absorbed; requests are not counted.
  - pending[i] clears on the edge that grants requester i.
  - If req[i] is asserted in that same cycle, pending[i] stays 1 (new request queued).
  - A request from the current owner during COUNT or DONE queues normally.
- States:
  - IDLE:
    - If any pending bit is set: state<=COUNT, led<=0, tick counter<=0.
    - Grant goes to the sole pending requester. If both are pending, grant goes to ~last_owner.
    - owner<=grantee, last_owner<=grantee.
    - Grant latency: req pulse sampled at edge n → pending at n → COUNT/owner valid after edge n+1.
  - COUNT:
    - Tick counter increments every cycle. tick=1 when counter==TICK_DIV-1, then the counter wraps to 0.
    - On tick: if led==MAX_COUNT, state<=DONE (led holds MAX_COUNT); else led<=led+1.
    - Each LED value is displayed for exactly TICK_DIV cycles. COUNT lasts (MAX_COUNT+1)*TICK_DIV cycles.
  - DONE:
    - done[owner]=1 (Moore output, decoded from state) and led=MAX_COUNT.
    - On tick: state<=IDLE, led<=0. DONE lasts exactly TICK_DIV cycles.
    - If a pending bit is set on entering IDLE, the next grant occurs one cycle later. There is always one IDLE cycle between owners.
- Tick counter runs only in COUNT and DONE. It is held at 0 in IDLE.
- Arithmetic: led is unsigned LED_W bits and never wraps, because the MAX_COUNT compare precedes the increment. Tick counter is unsigned and wraps at TICK_DIV-1.
- Illegal state encoding → IDLE on the next edge, with led<=0.
- Reset mid-COUNT or mid-DONE: all registers go immediately (asynchronously) to reset values, and queued requests are discarded. After rst_btn deasserts, the block waits in IDLE for a new req.
- No combinational path from req to any output.

Test Plan:
- TICK_DIV=4, MAX_COUNT=3, req=2'b01 pulse sampled at edge 0:
  - busy=1, owner=0 after edge 1.
  - led=0,1,2,3 after edges 1,5,9,13.
  - done=2'b01 after edges 17–20.
  - IDLE with led=0 after edge 21.
- req=2'b11 in one cycle from reset:
  - owner 0 served first, then owner 1 granted one cycle after owner 0 leaves DONE.
  - done=2'b10 at the end of the second run.
- Repeated ties: after the run above, req=2'b11 again → owner=0 again (last_owner=1), confirming the round-robin pointer alternates.
- req[0] pulsed 3 times during the owner-1 COUNT → exactly one subsequent owner-0 run; pending is not a counter.
- req[1] asserted on the exact IDLE→COUNT grant edge for requester 1 → pending[1] remains 1 and a second owner-1 run follows.
- rst_btn driven low mid-COUNT (led=2) while pending[0]=1:
  - led, busy, done go to 0 asynchronously, before the next clk edge.
  - No run starts after release until a new req arrives.
